// File: rtl/issue_pkg.sv
// Shared types and constants for the in-order issue stage: register index width,
// decoded-control payload layout and the issue-queue entry record.
package issue_pkg;

    localparam int REG_W    = 5;
    localparam int NUM_REGS = 32;

    // Decoded-control payload layout, LSB first: ctrl flags, aluop, funct, imm.
    localparam int CTRL_W    = 5;
    localparam int ALUOP_W   = 2;
    localparam int FUNCT_W   = 10;
    localparam int IMM_W     = 32;
    localparam int CTRL_LSB  = 0;
    localparam int ALUOP_LSB = CTRL_LSB + CTRL_W;
    localparam int FUNCT_LSB = ALUOP_LSB + ALUOP_W;
    localparam int IMM_LSB   = FUNCT_LSB + FUNCT_W;
    localparam int PAYLOAD_DEF_W = IMM_LSB + IMM_W;

    typedef logic [REG_W-1:0] reg_idx_t;

    // Register-dependency part of a queue entry; the payload is stored alongside it.
    typedef struct packed {
        reg_idx_t rs1;
        reg_idx_t rs2;
        reg_idx_t rd;
        logic     uses_rs2;
        logic     regwrite;
    } iq_entry_t;

    // One-hot register mask; x0 never maps to a bit so it can never become busy.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic en, input reg_idx_t idx);
        logic [NUM_REGS-1:0] mask;
        mask = '0;
        if (en && (idx != '0))
            mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Register busy scoreboard: tracks destinations of issued instructions until writeback
// and flags read/write hazards for the queue head. Optional ISSUE_WB_BYPASS_EN.
module issue_scoreboard
    import issue_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en,
    input  reg_idx_t            set_rd,
    input  logic                clr_en,
    input  reg_idx_t            clr_rd,
    input  iq_entry_t           chk,
    output logic [NUM_REGS-1:0] busy,
    output logic                hazard
);

    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] busy_eff;

    assign set_mask = reg_onehot(set_en, set_rd);
    assign clr_mask = reg_onehot(clr_en, clr_rd);

`ifdef ISSUE_WB_BYPASS_EN
    // A writeback landing this cycle already frees its register for the hazard check.
    assign busy_eff = busy & ~clr_mask;
`else
    assign busy_eff = busy;
`endif

    assign hazard = busy_eff[chk.rs1]
                  | (chk.uses_rs2 & busy_eff[chk.rs2])
                  | (chk.regwrite & busy_eff[chk.rd]);

    // Set is OR-ed after the clear so an issue and writeback to one register leaves it busy.
    always_ff @(posedge clk) begin
        if (rst)
            busy <= '0;
        else
            busy <= (busy & ~clr_mask) | set_mask;
    end

endmodule

// File: rtl/issue_stage.sv
// In-order issue stage: decode-fed FIFO whose head issues once the busy scoreboard
// reports no hazard. Optional macro ISSUE_WB_BYPASS_EN enables writeback bypass.
module issue_stage
    import issue_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = PAYLOAD_DEF_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dec_valid,
    output logic                 dec_ready,
    input  logic [REG_W-1:0]     dec_rs1,
    input  logic [REG_W-1:0]     dec_rs2,
    input  logic [REG_W-1:0]     dec_rd,
    input  logic                 dec_uses_rs2,
    input  logic                 dec_regwrite,
    input  logic [PAYLOAD_W-1:0] dec_payload,
    output logic                 iss_valid,
    input  logic                 iss_ready,
    output logic [REG_W-1:0]     iss_rs1,
    output logic [REG_W-1:0]     iss_rs2,
    output logic [REG_W-1:0]     iss_rd,
    output logic [PAYLOAD_W-1:0] iss_payload,
    input  logic                 wb_valid,
    input  logic [REG_W-1:0]     wb_rd,
    input  logic                 flush,
    output logic [NUM_REGS-1:0]  busy,
    output logic [15:0]          stall_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    iq_entry_t            entry_mem   [DEPTH];
    logic [PAYLOAD_W-1:0] payload_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    iq_entry_t dec_entry;
    iq_entry_t head;
    logic      not_empty;
    logic      hazard;
    logic      push;
    logic      pop;

    assign dec_entry = '{rs1: dec_rs1, rs2: dec_rs2, rd: dec_rd,
                         uses_rs2: dec_uses_rs2, regwrite: dec_regwrite};

    assign head      = entry_mem[rd_ptr];
    assign not_empty = (count != '0);

    // Ready looks only at occupancy: a full queue does not accept a push even while popping.
    assign dec_ready = (count < CNT_W'(DEPTH));
    assign iss_valid = not_empty & ~hazard & ~flush;

    assign push = dec_valid & dec_ready & ~flush;
    assign pop  = iss_valid & iss_ready;

    assign iss_rs1     = head.rs1;
    assign iss_rs2     = head.rs2;
    assign iss_rd      = head.rd;
    assign iss_payload = payload_mem[rd_ptr];

    issue_scoreboard u_scoreboard (
        .clk    (clk),
        .rst    (rst),
        .set_en (pop & head.regwrite),
        .set_rd (head.rd),
        .clr_en (wb_valid),
        .clr_rd (wb_rd),
        .chk    (head),
        .busy   (busy),
        .hazard (hazard)
    );

    // Queue storage: data only, no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_mem[wr_ptr]   <= dec_entry;
            payload_mem[wr_ptr] <= dec_payload;
        end
    end

    // Queue control: pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (not_empty && hazard && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end

endmodule

// File: doc/issue_stage.md
ISSUE_STAGE -- requirements
Module: issue_stage

Interface
REQ-001 Parameter DEPTH, default 4, sets issue queue entries; power of two, 2..16.
REQ-002 Parameter PAYLOAD_W, default 49, sets decoded-control payload width (imm 32, funct 10, aluop 2, alusrc/memread/memwrite/memtoreg/branch 5).
REQ-003 Port clk, input, 1, sole clock; all state on posedge clk.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port dec_valid, input, 1, decode presents an instruction.
REQ-006 Port dec_ready, output, 1, queue can accept an instruction.
REQ-007 Ports dec_rs1 / dec_rs2 / dec_rd, input, 5 each, register indices.
REQ-008 Port dec_uses_rs2, input, 1, instruction reads rs2 (R-type, sw, beq).
REQ-009 Port dec_regwrite, input, 1, instruction writes rd.
REQ-010 Port dec_payload, input, PAYLOAD_W, opaque control bundle.
REQ-011 Port iss_valid, output, 1, head instruction is hazard-free.
REQ-012 Port iss_ready, input, 1, execute accepts the issued instruction.
REQ-013 Ports iss_rs1 / iss_rs2 / iss_rd, output, 5 each, and iss_payload, output, PAYLOAD_W, head entry fields.
REQ-014 Port wb_valid, input, 1, and wb_rd, input, 5, writeback completion clearing busy[wb_rd].
REQ-015 Port flush, input, 1, taken branch; discard queued instructions.
REQ-016 Port busy, output, 32, scoreboard state.
REQ-017 Port stall_cnt, output, 16, saturating hazard-stall cycle counter.

Function
REQ-018 Queue SHALL be in-order FIFO; push when dec_valid & dec_ready, pop when iss_valid & iss_ready.
REQ-019 dec_ready SHALL equal (count < DEPTH), independent of same-cycle pop; full queue with pop accepts no push that cycle.
REQ-020 Pointers SHALL wrap modulo DEPTH; count SHALL be DEPTH+1 values wide; simultaneous push and pop keeps count unchanged.
REQ-021 Entry pushed at edge N SHALL be issuable no earlier than cycle after N (minimum one-cycle latency); no decode-to-issue bypass.
REQ-022 Hazard SHALL be: busy[rs1] | (uses_rs2 & busy[rs2]) | (regwrite & busy[rd]); index 0 never busy.
REQ-023 iss_valid SHALL be combinational: queue non-empty & no hazard & ~flush; iss_* fields always reflect head entry.
REQ-024 On issue handshake with regwrite and rd != 0, busy[rd] SHALL set at that edge.
REQ-025 wb_valid SHALL clear busy[wb_rd] at that edge; wb_rd = 0 ignored.
REQ-026 Same-edge set and clear of one register: set wins.
REQ-027 Flush SHALL empty queue next edge, override same-cycle push and pop, and leave busy unchanged (in-flight writebacks still clear).
REQ-028 stall_cnt SHALL increment each cycle queue non-empty and hazard true, saturating at 0xFFFF.

Reset
REQ-029 rst SHALL clear pointers, count, busy (all zero) and stall_cnt; outputs after reset: dec_ready=1, iss_valid=0, busy=0, stall_cnt=0.
REQ-030 rst mid-operation SHALL drop queued entries and override all same-cycle push, issue, writeback and flush.

Configuration
REQ-031 Macro ISSUE_WB_BYPASS_EN defined: hazard uses busy masked by same-cycle writeback clear, so a dependent issues in the writeback cycle.
REQ-032 Macro undefined: hazard uses registered busy only; dependent issues one cycle after writeback.

Structure
REQ-033 Package issue_pkg SHALL hold REG_W=5, NUM_REGS=32, payload field offsets/widths, and the queue entry struct.
REQ-034 Scoreboard SHALL be sub-module issue_scoreboard (busy vector, set/clear, hazard check); FIFO stays in issue_stage.

Verification
REQ-035 Reset then push addi x2,x0,5 (rd=2, regwrite) -> iss_valid next cycle, busy[2]=1 after issue.
REQ-036 Push add x4,x2,x2 while busy[2]=1 -> iss_valid=0, stall_cnt counts; wb_valid, wb_rd=2 -> issue same cycle with ISSUE_WB_BYPASS_EN, one cycle later without.
REQ-037 iss_ready=0, push 4 entries -> dec_ready=0 at count 4; 5th dec_valid not accepted; then pop 4 in order, wrap verified.
REQ-038 Issue with rd=5 and wb_rd=5 same edge -> busy[5]=1; rd=0 instruction -> busy unchanged.
REQ-039 flush with 3 queued and dec_valid=1 -> count=0 next cycle, busy bits of issued instructions retained.
REQ-040 rst asserted with 2 queued and busy[7]=1 -> next cycle count=0, busy=0, iss_valid=0, dec_ready=1.
